btle_tx_sequencer: RTL and testbench

Synthesizable controller that sits directly in front of btle_tx and replaces bench-side setup and launch sequencing.
- Accepts a valid/ready load stream and forwards it to btle_tx's write ports: Gaussian taps, cos/sin tables and PDU octets.
- Derives preamble and access-address byte order from the channel number and access address.
- Launches back-to-back transmissions with programmable repeat count and inter-packet gap.
- Supervises each packet's IQ output with a sample counter and a timeout.

---
 rtl/btle_tx_sequencer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_btle_tx_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btle_tx_sequencer.sv
// Launch/load controller in front of btle_tx: forwards table/PDU loads, derives
// preamble and on-air access address, and sequences repeated transmissions.
module btle_tx_sequencer #(
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int GAUSS_FILTER_BIT_WIDTH   = 16,
    parameter int NUM_TAP_HALF             = 9,
    parameter int SIN_COS_ADDR_BIT_WIDTH   = 11,
    parameter int IQ_BIT_WIDTH             = 8,
    parameter int PDU_ADDR_BIT_WIDTH       = 6,
    parameter int GAP_BIT_WIDTH            = 16,
    parameter int MAX_SAMPLE               = 4095
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ld_valid,
    output logic                                ld_ready,
    input  logic [1:0]                          ld_sel,
    input  logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   ld_addr,
    input  logic [GAUSS_FILTER_BIT_WIDTH-1:0]   ld_data,
    input  logic                                ld_last,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number_in,
    input  logic [31:0]                         access_address_in,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_init_in,
    input  logic [7:0]                          repeat_count,
    input  logic [GAP_BIT_WIDTH-1:0]            gap_cycles,
    input  logic                                start,
    input  logic                                abort,
    output logic [3:0]                          gauss_filter_tap_index,
    output logic [GAUSS_FILTER_BIT_WIDTH-1:0]   gauss_filter_tap_value,
    output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   cos_table_write_address,
    output logic [IQ_BIT_WIDTH-1:0]             cos_table_write_data,
    output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   sin_table_write_address,
    output logic [IQ_BIT_WIDTH-1:0]             sin_table_write_data,
    output logic [PDU_ADDR_BIT_WIDTH-1:0]       pdu_octet_mem_addr,
    output logic [7:0]                          pdu_octet_mem_data,
    output logic [7:0]                          preamble,
    output logic [31:0]                         access_address,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
    output logic                                crc_state_init_bit_load,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    output logic                                channel_number_load,
    output logic                                tx_start,
    input  logic                                iq_valid,
    input  logic                                iq_valid_last,
    output logic                                busy,
    output logic                                done,
    output logic                                err_timeout,
    output logic [11:0]                         sample_count,
    output logic [7:0]                          pkt_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CFG  = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_TX   = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    localparam logic [SIN_COS_ADDR_BIT_WIDTH-1:0] TAP_LAST   = SIN_COS_ADDR_BIT_WIDTH'(NUM_TAP_HALF - 1);
    localparam logic [SIN_COS_ADDR_BIT_WIDTH-1:0] TABLE_LAST = '1;
    localparam logic [11:0]                       SAMPLE_MAX = 12'(MAX_SAMPLE);

    logic [2:0]                          state_q, state_d;
    logic                                tap_ok_q, tap_ok_d, cos_ok_q, cos_ok_d;
    logic                                sin_ok_q, sin_ok_d, pdu_ok_q, pdu_ok_d;
    logic [3:0]                          tap_index_q, tap_index_d;
    logic [GAUSS_FILTER_BIT_WIDTH-1:0]   tap_value_q, tap_value_d;
    logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   cos_addr_q, cos_addr_d, sin_addr_q, sin_addr_d;
    logic [IQ_BIT_WIDTH-1:0]             cos_data_q, cos_data_d, sin_data_q, sin_data_d;
    logic [PDU_ADDR_BIT_WIDTH-1:0]       pdu_addr_q, pdu_addr_d;
    logic [7:0]                          pdu_data_q, pdu_data_d;
    logic [7:0]                          preamble_q, preamble_d;
    logic [31:0]                         aa_q, aa_d;
    logic [CRC_STATE_BIT_WIDTH-1:0]      crc_q, crc_d;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] chan_q, chan_d;
    logic [7:0]                          repeat_q, repeat_d;
    logic [GAP_BIT_WIDTH-1:0]            gap_cnt_q, gap_cnt_d;
    logic [11:0]                         sample_count_q, sample_count_d;
    logic [7:0]                          pkt_count_q, pkt_count_d;
    logic                                done_q, done_d;
    logic                                err_q, err_d;
    logic                                ld_fire;
    logic                                all_ok;

    // Load handshake: a beat transfers on a cycle where ld_valid && ld_ready;
    // ld_ready is high only while idle and out of reset, and never depends on ld_valid.
    assign ld_ready = (state_q == ST_IDLE) && !rst;
    assign ld_fire  = ld_valid && ld_ready;
    assign all_ok   = tap_ok_q && cos_ok_q && sin_ok_q && pdu_ok_q;

    always_comb begin
        tap_ok_d    = tap_ok_q;
        cos_ok_d    = cos_ok_q;
        sin_ok_d    = sin_ok_q;
        pdu_ok_d    = pdu_ok_q;
        tap_index_d = tap_index_q;
        tap_value_d = tap_value_q;
        cos_addr_d  = cos_addr_q;
        cos_data_d  = cos_data_q;
        sin_addr_d  = sin_addr_q;
        sin_data_d  = sin_data_q;
        pdu_addr_d  = pdu_addr_q;
        pdu_data_d  = pdu_data_q;
        if (ld_fire) begin
            case (ld_sel)
                2'd0: begin
                    tap_index_d = ld_addr[3:0];
                    tap_value_d = ld_data;
                    if (ld_addr == TAP_LAST) tap_ok_d = 1'b1;
                end
                2'd1: begin
                    cos_addr_d = ld_addr;
                    cos_data_d = ld_data[IQ_BIT_WIDTH-1:0];
                    if (ld_addr == TABLE_LAST) cos_ok_d = 1'b1;
                end
                2'd2: begin
                    sin_addr_d = ld_addr;
                    sin_data_d = ld_data[IQ_BIT_WIDTH-1:0];
                    if (ld_addr == TABLE_LAST) sin_ok_d = 1'b1;
                end
                default: begin
                    pdu_addr_d = ld_addr[PDU_ADDR_BIT_WIDTH-1:0];
                    pdu_data_d = ld_data[7:0];
                    if (ld_last) pdu_ok_d = 1'b1;
                end
            endcase
        end
    end

    // Advertising channels 37..39 use the alternate preamble.
    always_comb begin
        preamble_d = 8'h55;
        if (channel_number_in == CHANNEL_NUMBER_BIT_WIDTH'(37) ||
            channel_number_in == CHANNEL_NUMBER_BIT_WIDTH'(38) ||
            channel_number_in == CHANNEL_NUMBER_BIT_WIDTH'(39))
            preamble_d = 8'hAA;
        aa_d = {access_address_in[7:0], access_address_in[15:8],
                access_address_in[23:16], access_address_in[31:24]};
    end

    always_comb begin
        state_d        = state_q;
        crc_d          = crc_q;
        chan_d         = chan_q;
        repeat_d       = repeat_q;
        gap_cnt_d      = gap_cnt_q;
        sample_count_d = sample_count_q;
        pkt_count_d    = pkt_count_q;
        done_d         = 1'b0;
        err_d          = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start && all_ok) begin
                    state_d     = ST_CFG;
                    chan_d      = channel_number_in;
                    crc_d       = crc_init_in;
                    repeat_d    = repeat_count;
                    pkt_count_d = 8'd0;
                    err_d       = 1'b0;
                end
            end
            ST_CFG: state_d = ST_ARM;
            ST_ARM: begin
                sample_count_d = 12'd0;
                state_d        = ST_TX;
            end
            ST_TX: begin
                if (iq_valid && sample_count_q != SAMPLE_MAX)
                    sample_count_d = sample_count_q + 12'd1;
                if (iq_valid_last) begin
                    pkt_count_d = pkt_count_q + 8'd1;
                    if (pkt_count_q == repeat_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_cycles;
                    end
                end else if (sample_count_d == SAMPLE_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                // A gap of 0 or 1 both spend a single cycle here.
                if (gap_cnt_q <= GAP_BIT_WIDTH'(1)) state_d = ST_ARM;
                else gap_cnt_d = gap_cnt_q - GAP_BIT_WIDTH'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort drops the sequence but keeps the counters; a coincident last sample still counts.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = err_q;
            if (state_q != ST_TX) sample_count_d = sample_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            tap_ok_q       <= 1'b0;
            cos_ok_q       <= 1'b0;
            sin_ok_q       <= 1'b0;
            pdu_ok_q       <= 1'b0;
            tap_index_q    <= '0;
            tap_value_q    <= '0;
            cos_addr_q     <= '0;
            cos_data_q     <= '0;
            sin_addr_q     <= '0;
            sin_data_q     <= '0;
            pdu_addr_q     <= '0;
            pdu_data_q     <= '0;
            preamble_q     <= 8'h55;
            aa_q           <= '0;
            crc_q          <= '0;
            chan_q         <= '0;
            repeat_q       <= '0;
            gap_cnt_q      <= '0;
            sample_count_q <= '0;
            pkt_count_q    <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            tap_ok_q       <= tap_ok_d;
            cos_ok_q       <= cos_ok_d;
            sin_ok_q       <= sin_ok_d;
            pdu_ok_q       <= pdu_ok_d;
            tap_index_q    <= tap_index_d;
            tap_value_q    <= tap_value_d;
            cos_addr_q     <= cos_addr_d;
            cos_data_q     <= cos_data_d;
            sin_addr_q     <= sin_addr_d;
            sin_data_q     <= sin_data_d;
            pdu_addr_q     <= pdu_addr_d;
            pdu_data_q     <= pdu_data_d;
            preamble_q     <= preamble_d;
            aa_q           <= aa_d;
            crc_q          <= crc_d;
            chan_q         <= chan_d;
            repeat_q       <= repeat_d;
            gap_cnt_q      <= gap_cnt_d;
            sample_count_q <= sample_count_d;
            pkt_count_q    <= pkt_count_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign gauss_filter_tap_index  = tap_index_q;
    assign gauss_filter_tap_value  = tap_value_q;
    assign cos_table_write_address = cos_addr_q;
    assign cos_table_write_data    = cos_data_q;
    assign sin_table_write_address = sin_addr_q;
    assign sin_table_write_data    = sin_data_q;
    assign pdu_octet_mem_addr      = pdu_addr_q;
    assign pdu_octet_mem_data      = pdu_data_q;
    assign preamble                = preamble_q;
    assign access_address          = aa_q;
    assign crc_state_init_bit      = crc_q;
    assign channel_number          = chan_q;
    assign crc_state_init_bit_load = (state_q == ST_CFG);
    assign channel_number_load     = (state_q == ST_CFG);
    assign tx_start                = (state_q == ST_ARM);
    assign busy                    = (state_q != ST_IDLE);
    assign done                    = done_q;
    assign err_timeout             = err_q;
    assign sample_count            = sample_count_q;
    assign pkt_count               = pkt_count_q;

endmodule

// File: tb/tb_btle_tx_sequencer.sv
// Directed bench for btle_tx_sequencer: a timeline model schedules the expected
// pulse cycles and busy window; a negedge process compares them every cycle.
module tb_btle_tx_sequencer;

    localparam int BIG = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [1:0]  ld_sel = '0;
    logic [10:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic [5:0]  channel_number_in = 6'd37;
    logic [31:0] access_address_in = 32'hD6BE898E;
    logic [23:0] crc_init_in = 24'h555555;
    logic [7:0]  repeat_count = '0;
    logic [15:0] gap_cycles = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  gauss_filter_tap_index;
    logic [15:0] gauss_filter_tap_value;
    logic [10:0] cos_table_write_address, sin_table_write_address;
    logic [7:0]  cos_table_write_data, sin_table_write_data;
    logic [5:0]  pdu_octet_mem_addr;
    logic [7:0]  pdu_octet_mem_data;
    logic [7:0]  preamble;
    logic [31:0] access_address;
    logic [23:0] crc_state_init_bit;
    logic        crc_state_init_bit_load;
    logic [5:0]  channel_number;
    logic        channel_number_load;
    logic        tx_start;
    logic        iq_valid = 1'b0;
    logic        iq_valid_last = 1'b0;
    logic        busy, done, err_timeout;
    logic [11:0] sample_count;
    logic [7:0]  pkt_count;

    btle_tx_sequencer dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last),
        .channel_number_in(channel_number_in), .access_address_in(access_address_in),
        .crc_init_in(crc_init_in), .repeat_count(repeat_count), .gap_cycles(gap_cycles),
        .start(start), .abort(abort),
        .gauss_filter_tap_index(gauss_filter_tap_index), .gauss_filter_tap_value(gauss_filter_tap_value),
        .cos_table_write_address(cos_table_write_address), .sin_table_write_address(sin_table_write_address),
        .cos_table_write_data(cos_table_write_data), .sin_table_write_data(sin_table_write_data),
        .pdu_octet_mem_addr(pdu_octet_mem_addr), .pdu_octet_mem_data(pdu_octet_mem_data),
        .preamble(preamble), .access_address(access_address),
        .crc_state_init_bit(crc_state_init_bit), .crc_state_init_bit_load(crc_state_init_bit_load),
        .channel_number(channel_number), .channel_number_load(channel_number_load),
        .tx_start(tx_start), .iq_valid(iq_valid), .iq_valid_last(iq_valid_last),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .sample_count(sample_count), .pkt_count(pkt_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    int tx_q[$];
    int done_q[$];
    int cfg_q[$];
    int busy_from = 0;
    int busy_to   = 0;
    int m_next_tx = -1;
    int m_pkt     = 0;
    int m_rep     = 0;
    bit f_tap = 0, f_cos = 0, f_sin = 0, f_pdu = 0;
    logic [3:0]  e_tap_idx = '0;
    logic [15:0] e_tap_val = '0;
    logic [10:0] e_cos_a = '0, e_sin_a = '0;
    logic [7:0]  e_cos_d = '0, e_sin_d = '0;
    logic [5:0]  e_pdu_a = '0;
    logic [7:0]  e_pdu_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_busy();
        return (cyc >= busy_from) && (cyc < busy_to);
    endfunction

    always @(negedge clk) begin : cmp_proc
        bit e_tx, e_done, e_cfg, e_busy;
        if (cmp_en) begin
            e_tx = (tx_q.size() > 0) && (tx_q[0] == cyc);
            if (e_tx) void'(tx_q.pop_front());
            e_done = (done_q.size() > 0) && (done_q[0] == cyc);
            if (e_done) void'(done_q.pop_front());
            e_cfg = (cfg_q.size() > 0) && (cfg_q[0] == cyc);
            if (e_cfg) void'(cfg_q.pop_front());
            e_busy = model_busy();
            chk("tx_start", 32'(tx_start), 32'(e_tx));
            chk("done", 32'(done), 32'(e_done));
            chk("crc_load", 32'(crc_state_init_bit_load), 32'(e_cfg));
            chk("chan_load", 32'(channel_number_load), 32'(e_cfg));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("ld_ready", 32'(ld_ready), 32'(!e_busy && !rst));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cancel_after(input int t);
        while (tx_q.size() > 0 && tx_q[$] > t) void'(tx_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > t) void'(done_q.pop_back());
        while (cfg_q.size() > 0 && cfg_q[$] > t) void'(cfg_q.pop_back());
        if (busy_to > t + 1) busy_to = t + 1;
        m_next_tx = -1;
    endtask

    task automatic check_load_ports();
        chk("tap_idx", 32'(gauss_filter_tap_index), 32'(e_tap_idx));
        chk("tap_val", 32'(gauss_filter_tap_value), 32'(e_tap_val));
        chk("cos_addr", 32'(cos_table_write_address), 32'(e_cos_a));
        chk("cos_data", 32'(cos_table_write_data), 32'(e_cos_d));
        chk("sin_addr", 32'(sin_table_write_address), 32'(e_sin_a));
        chk("sin_data", 32'(sin_table_write_data), 32'(e_sin_d));
        chk("pdu_addr", 32'(pdu_octet_mem_addr), 32'(e_pdu_a));
        chk("pdu_data", 32'(pdu_octet_mem_data), 32'(e_pdu_d));
    endtask

    task automatic load_beat(input logic [1:0] sel, input int addr, input logic [15:0] data, input logic last);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = 11'(addr);
        ld_data  = data;
        ld_last  = last;
        case (sel)
            2'd0: begin e_tap_idx = 4'(addr); e_tap_val = data; if (addr == 8) f_tap = 1; end
            2'd1: begin e_cos_a = 11'(addr); e_cos_d = data[7:0]; if (addr == 2047) f_cos = 1; end
            2'd2: begin e_sin_a = 11'(addr); e_sin_d = data[7:0]; if (addr == 2047) f_sin = 1; end
            default: begin e_pdu_a = 6'(addr); e_pdu_d = data[7:0]; if (last) f_pdu = 1; end
        endcase
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check_load_ports();
    endtask

    task automatic do_start();
        start = 1'b1;
        if (!model_busy() && f_tap && f_cos && f_sin && f_pdu) begin
            cfg_q.push_back(cyc + 1);
            tx_q.push_back(cyc + 2);
            m_next_tx = cyc + 2;
            busy_from = cyc + 1;
            busy_to   = BIG;
            m_pkt     = 0;
            m_rep     = int'(repeat_count);
        end
        step();
        start = 1'b0;
    endtask

    task automatic model_end(input bit ab);
        int g;
        m_pkt++;
        if (ab) begin
            cancel_after(cyc);
        end else if (m_pkt - 1 == m_rep) begin
            done_q.push_back(cyc + 1);
            busy_to   = cyc + 1;
            m_next_tx = -1;
        end else begin
            g = int'(gap_cycles);
            m_next_tx = cyc + 1 + ((g > 1) ? g : 1);
            tx_q.push_back(m_next_tx);
        end
    endtask

    task automatic wait_tx();
        while (cyc < m_next_tx) step();
        step();
    endtask

    task automatic run_packet(input int nsamp, input bit ab_last);
        wait_tx();
        for (int i = 0; i < nsamp; i++) begin
            iq_valid      = 1'b1;
            iq_valid_last = (i == nsamp - 1);
            if (i == nsamp - 1) begin
                abort = ab_last;
                model_end(ab_last);
            end
            step();
        end
        iq_valid      = 1'b0;
        iq_valid_last = 1'b0;
        abort         = 1'b0;
        chk("pkt_samples", 32'(sample_count), 32'(nsamp));
        chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cancel_after(cyc);
        f_tap = 0; f_cos = 0; f_sin = 0; f_pdu = 0;
        e_tap_idx = '0; e_tap_val = '0; e_cos_a = '0; e_cos_d = '0;
        e_sin_a = '0; e_sin_d = '0; e_pdu_a = '0; e_pdu_d = '0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        step();
        cmp_en = 1'b1;
        chk("rst_preamble", 32'(preamble), 32'h55);
        chk("rst_aa", access_address, 32'h0);
        chk("rst_samples", 32'(sample_count), 32'h0);
        chk("rst_pkt", 32'(pkt_count), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);
        chk("rst_chan", 32'(channel_number), 32'h0);
        chk("rst_crc", 32'(crc_state_init_bit), 32'h0);
        check_load_ports();
        step();
        step();
        rst = 1'b0;
        step();
        chk("preamble_ch37", 32'(preamble), 32'hAA);
        chk("aa_reversed", access_address, 32'h8E89BED6);

        // out-of-range tap forwarded but does not complete the tap set
        load_beat(2'd0, 12, 16'h0BAD, 1'b0);
        chk("tap_oor_idx", 32'(gauss_filter_tap_index), 32'd12);
        for (int a = 0; a < 2048; a++) load_beat(2'd1, a, {8'h5A, 8'(a * 3)}, 1'b0);
        for (int a = 0; a < 2048; a++) load_beat(2'd2, a, {8'hC3, 8'(a * 5 + 1)}, 1'b0);
        for (int a = 0; a < 20; a++) load_beat(2'd3, a, {8'hFF, 8'(a + 64)}, a == 19);
        do_start();
        step();
        for (int a = 0; a < 9; a++) load_beat(2'd0, a, 16'(a * 16'h1111 + 16'h0101), 1'b0);

        do_start();
        chk("chan_latched", 32'(channel_number), 32'd37);
        chk("crc_latched", 32'(crc_state_init_bit), 32'h555555);
        step();
        chk("tx_start_plus2", 32'(tx_start), 32'd1);
        run_packet(30, 1'b0);
        chk("done_after_last", 32'(done), 32'd1);
        chk("pkt_one", 32'(pkt_count), 32'd1);

        channel_number_in = 6'd10;
        step();
        chk("preamble_ch10", 32'(preamble), 32'h55);
        chk("aa_hold", access_address, 32'h8E89BED6);

        // three packets with a 100-cycle gap; start during the gap is ignored
        repeat_count = 8'd2;
        gap_cycles   = 16'd100;
        do_start();
        run_packet(20, 1'b0);
        do_start();
        repeat (98) step();
        chk("gap_pre", 32'(tx_start), 32'd0);
        step();
        chk("gap_101", 32'(tx_start), 32'd1);
        run_packet(25, 1'b0);
        run_packet(10, 1'b0);
        chk("pkt_three", 32'(pkt_count), 32'd3);
        chk("done_three", 32'(done), 32'd1);
        step();

        // timeout: iq_valid without iq_valid_last
        repeat_count = 8'd0;
        do_start();
        wait_tx();
        for (int i = 0; i < 4095; i++) begin
            iq_valid = 1'b1;
            if (i == 4094) begin
                chk("pre_timeout_cnt", 32'(sample_count), 32'd4094);
                chk("pre_timeout_err", 32'(err_timeout), 32'd0);
                busy_to   = cyc + 1;
                m_next_tx = -1;
            end
            step();
        end
        iq_valid = 1'b0;
        chk("timeout_err", 32'(err_timeout), 32'd1);
        chk("timeout_cnt", 32'(sample_count), 32'd4095);
        chk("timeout_pkt", 32'(pkt_count), 32'd0);
        step();
        chk("err_sticky", 32'(err_timeout), 32'd1);
        do_start();
        chk("err_cleared", 32'(err_timeout), 32'd0);
        run_packet(8, 1'b0);

        // abort 50 cycles into TX
        repeat_count = 8'd1;
        gap_cycles   = 16'd200;
        do_start();
        wait_tx();
        repeat (50) begin
            iq_valid = 1'b1;
            step();
        end
        iq_valid = 1'b0;
        abort    = 1'b1;
        cancel_after(cyc);
        step();
        abort = 1'b0;
        chk("abort_samples", 32'(sample_count), 32'd50);
        chk("abort_pkt", 32'(pkt_count), 32'd0);
        step();

        // abort coincident with iq_valid_last still counts the packet
        repeat_count = 8'd3;
        gap_cycles   = 16'd5;
        do_start();
        run_packet(15, 1'b1);
        step();

        // reset during the gap
        repeat_count = 8'd1;
        gap_cycles   = 16'd100;
        do_start();
        run_packet(10, 1'b0);
        repeat (20) step();
        do_reset(2);
        step();
        check_load_ports();
        chk("rst2_pkt", 32'(pkt_count), 32'd0);
        chk("rst2_samples", 32'(sample_count), 32'd0);
        chk("rst2_chan", 32'(channel_number), 32'd0);
        chk("rst2_crc", 32'(crc_state_init_bit), 32'd0);
        do_start();
        step();

        // only the final entry of each target is needed; sin last entry withheld
        crc_init_in = 24'hA1B2C3;
        load_beat(2'd0, 8, 16'h1234, 1'b0);
        load_beat(2'd1, 2047, 16'h00EE, 1'b0);
        load_beat(2'd2, 2046, 16'h0077, 1'b0);
        load_beat(2'd3, 5, 16'h0099, 1'b1);
        do_start();
        step();
        load_beat(2'd2, 2047, 16'h0F31, 1'b0);
        repeat_count = 8'd0;
        do_start();
        chk("crc_latched2", 32'(crc_state_init_bit), 32'hA1B2C3);
        run_packet(5, 1'b0);
        chk("done_final", 32'(done), 32'd1);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
